mult_unit: RTL and testbench
============================

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have parameter RADIX_BITS, default 1, meaning the number of multiplier bits retired per cycle; legal values are 1, 2 and 4.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en_mult, input, 1 bit: multiply request level, driven by the ALU while a MULT is selected.
REQ-005 The block SHALL have ports a and b, input, 32 bits each: multiplicand and multiplier.
REQ-006 The block SHALL have port busy, output, 1 bit: high while in state BUSY.
REQ-007 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-008 The block SHALL have ports product_hi and product_lo, output, 32 bits each: upper and lower words of the last completed 64-bit product, consumed by the ALU for MFHI/MFLO.

Function
REQ-009 The block SHALL implement states IDLE, BUSY and DONE, with ITER = 32/RADIX_BITS.
REQ-010 The block SHALL accept a request only on a rising edge of en_mult (en_mult=1 and its registered previous value=0) while in IDLE or DONE; a level held high SHALL NOT restart the operation.
REQ-011 On accept, the block SHALL capture a and b, clear the 64-bit accumulator, load the iteration counter with ITER, and enter BUSY.
REQ-012 In BUSY, each cycle the block SHALL add (multiplicand × the low RADIX_BITS multiplier bits), shifted into position, to the accumulator, shift the multiplier right by RADIX_BITS, and decrement the counter.
REQ-013 When the counter reaches zero, the block SHALL register the accumulator into product_hi/product_lo and enter DONE; done SHALL be high for exactly that one cycle, after which the block returns to IDLE unless a new request is accepted.
REQ-014 done SHALL rise ITER+1 rising edges after the accepting edge (33 for RADIX_BITS=1).
REQ-015 All arithmetic SHALL be a full 64-bit product with no truncation or overflow flag.
REQ-016 Rising edges of en_mult during BUSY SHALL be ignored without queuing, and the in-flight operation SHALL complete unchanged.
REQ-017 product_hi/product_lo SHALL hold their value from completion until the next completion and SHALL NOT change during BUSY.
REQ-018 An operand of zero SHALL still take the full ITER cycles, with no early termination.

Reset
REQ-019 When reset is asserted, the block SHALL immediately force the state to IDLE, busy=0, done=0, product_hi=0, product_lo=0, the accumulator, counter and edge-detect register to 0, abandoning any in-flight operation.
REQ-020 On reset deassertion with en_mult already high, the block SHALL NOT start an operation until en_mult is observed low and then high.

Configuration
REQ-021 With macro MULT_SIGNED_EN defined, the block SHALL add input port is_signed (1 bit, captured on accept); when it is 1, the block SHALL multiply the operand magnitudes and two's-complement negate the 64-bit result if the operand signs differ.
REQ-022 Without MULT_SIGNED_EN, the is_signed port SHALL be absent and all operands SHALL be treated as unsigned.

Structure
REQ-023 The state enumeration mult_state_t and constant MULT_WIDTH=32 SHALL be placed in the shared package global_types.
REQ-024 The block SHALL be a single module with no sub-modules; ITER and the counter width SHALL be derived from RADIX_BITS.

Verification
REQ-025 The bench SHALL cover: a=7, b=6, rising edge of en_mult -> done on edge 33, product_hi=0, product_lo=42, busy high for 32 cycles.
REQ-026 The bench SHALL cover: a=b=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001.
REQ-027 The bench SHALL cover: en_mult held high for 100 cycles -> exactly one done pulse; product stable afterwards.
REQ-028 The bench SHALL cover: a second en_mult edge at cycle 10 of BUSY -> ignored; a single done with the first product; then an edge in the DONE cycle -> accepted and busy=1 on the next cycle.
REQ-029 The bench SHALL cover: reset asserted at cycle 15 of BUSY -> all outputs 0 immediately; no done after release.
REQ-030 The bench SHALL cover, with MULT_SIGNED_EN, is_signed=1, a=-3, b=5 -> product_hi=0xFFFFFFFF, product_lo=0xFFFFFFF1; the same operands with is_signed=0 -> product_hi=0x00000004, product_lo=0xFFFFFFF1.

Source files
------------

// File: rtl/global_types.sv
// Shared types for the multiply unit: state enumeration and operand width.
package global_types;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_unit.sv
// Iterative radix-2^RADIX_BITS multiplier producing a 64-bit HI/LO product.
// Optional signed mode is enabled by defining MULT_SIGNED_EN (adds is_signed).
//
// state | meaning
// IDLE  | waiting for a rising edge of en_mult
// BUSY  | retiring RADIX_BITS multiplier bits per cycle
// DONE  | product registered, done pulse; a new edge may restart here
module mult_unit
  import global_types::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en_mult,
  input  logic [MULT_WIDTH-1:0] a,
  input  logic [MULT_WIDTH-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic                  is_signed,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [MULT_WIDTH-1:0] product_hi,
  output logic [MULT_WIDTH-1:0] product_lo
);

  localparam int ITER  = MULT_WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int PW    = 2 * MULT_WIDTH;

  mult_state_t state, state_nxt;

  logic                  en_q;
  logic                  seen_low;
  logic [PW-1:0]         mcand;
  logic [MULT_WIDTH-1:0] mplier;
  logic [PW-1:0]         acc;
  logic [CNT_W-1:0]      cnt;

  logic                  accept;
  logic                  last;
  logic [MULT_WIDTH-1:0] mag_a;
  logic [MULT_WIDTH-1:0] mag_b;
  logic [RADIX_BITS-1:0] digit;
  logic [PW-1:0]         acc_next;
  logic [PW-1:0]         result;

  // seen_low keeps a level already high at reset release from counting as an edge
  assign accept = en_mult && !en_q && seen_low && (state != BUSY);
  assign last   = (cnt == CNT_W'(1));
  assign digit  = mplier[RADIX_BITS-1:0];
  assign acc_next = acc + mcand * {{(PW-RADIX_BITS){1'b0}}, digit};

`ifdef MULT_SIGNED_EN
  logic neg_q;

  assign mag_a  = (is_signed && a[MULT_WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b  = (is_signed && b[MULT_WIDTH-1]) ? (~b + 1'b1) : b;
  assign result = neg_q ? (~acc_next + 1'b1) : acc_next;
`else
  assign mag_a  = a;
  assign mag_b  = b;
  assign result = acc_next;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      seen_low   <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      product_hi <= '0;
      product_lo <= '0;
`ifdef MULT_SIGNED_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      en_q <= en_mult;
      if (!en_mult) seen_low <= 1'b1;
      if (accept) begin
        mcand  <= {{MULT_WIDTH{1'b0}}, mag_a};
        mplier <= mag_b;
        acc    <= '0;
        cnt    <= CNT_W'(ITER);
`ifdef MULT_SIGNED_EN
        neg_q  <= is_signed && (a[MULT_WIDTH-1] ^ b[MULT_WIDTH-1]);
`endif
      end else if (state == BUSY) begin
        acc    <= acc_next;
        mcand  <= mcand << RADIX_BITS;
        mplier <= mplier >> RADIX_BITS;
        cnt    <= cnt - CNT_W'(1);
        if (last) begin
          product_hi <= result[PW-1:MULT_WIDTH];
          product_lo <= result[MULT_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed table, corner sequences, random ops.
// Signed checks are compiled in when MULT_SIGNED_EN is defined.
module tb_mult_unit;

  localparam int RB   = 1;
  localparam int ITER = 32 / RB;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en_mult = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] product_hi, product_lo;
`ifdef MULT_SIGNED_EN
  logic        is_signed = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] last_exp = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[7];

  mult_unit #(.RADIX_BITS(RB)) dut (
    .clock      (clock),
    .reset      (reset),
    .en_mult    (en_mult),
    .a          (a),
    .b          (b),
`ifdef MULT_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    longint sx, sy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Edge 1 is the accepting edge; done must be seen after edge ITER+1.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        input logic [63:0] exp, input string tag);
    int edge_n, done_edge, busy_n;
    logic stable;
    a = xa;
    b = xb;
    en_mult = 1'b1;
    tick();
    en_mult = 1'b0;
    edge_n = 1;
    done_edge = 0;
    busy_n = 0;
    stable = 1'b1;
    while (edge_n < 60 && done_edge == 0) begin
      if (done) done_edge = edge_n;
      else begin
        if (busy) busy_n++;
        if ({product_hi, product_lo} !== last_exp) stable = 1'b0;
        tick();
        edge_n++;
      end
    end
    check({tag, "_done_edge"}, 64'(done_edge), 64'(ITER + 1));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(ITER));
    check({tag, "_prod_stable_busy"}, 64'(stable), 64'd1);
    check({tag, "_product"}, {product_hi, product_lo}, exp);
    last_exp = exp;
    tick();
    check({tag, "_done_single"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cnt, edge_n;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd7,        32'd6,        64'h0000_0000_0000_002A};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,        32'h12345678, 64'h0};
    vecs[3] = '{32'h9ABCDEF0, 32'd0,        64'h0};
    vecs[4] = '{32'd1,        32'hFFFFFFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'h80000000, 32'd2,        64'h0000_0001_0000_0000};
    vecs[6] = '{32'hFFFFFFFF, 32'd2,        64'h0000_0001_FFFF_FFFE};

    // reset state
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", {product_hi, product_lo}, 64'h0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));
    end

    // level held high: exactly one operation
    a = 32'd3;
    b = 32'd5;
    en_mult = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) cnt++;
    end
    check("held_done_count", 64'(cnt), 64'd1);
    check("held_product", {product_hi, product_lo}, 64'd15);
    en_mult = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("held_product_after", {product_hi, product_lo}, 64'd15);
    last_exp = 64'd15;

    // second edge during BUSY is ignored; edge in DONE is accepted
    a = 32'd100;
    b = 32'd200;
    en_mult = 1'b1;
    tick();
    en_mult = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    a = 32'd5;
    b = 32'd5;
    en_mult = 1'b1;
    tick();
    en_mult = 1'b0;
    edge_n = 11;
    while (!done && edge_n < 60) begin
      tick();
      edge_n++;
    end
    check("ign_done_edge", 64'(edge_n), 64'(ITER + 1));
    check("ign_product", {product_hi, product_lo}, 64'd20000);
    a = 32'd9;
    b = 32'd9;
    en_mult = 1'b1;
    tick();
    check("done_edge_busy", 64'(busy), 64'd1);
    check("done_edge_nodone", 64'(done), 64'd0);
    en_mult = 1'b0;
    cnt = 0;
    while (!done && cnt < 60) begin
      tick();
      cnt++;
    end
    check("restart_product", {product_hi, product_lo}, 64'd81);
    tick();

    // reset in the middle of BUSY, with en_mult held high through release
    a = 32'd2;
    b = 32'd3;
    en_mult = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_product", {product_hi, product_lo}, 64'h0);
    tick();
    tick();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    check("postrst_no_start", 64'(cnt), 64'd0);
    last_exp = '0;
    en_mult = 1'b0;
    tick();
    run_op(32'd6, 32'd7, 64'd42, "postrst_op");

`ifdef MULT_SIGNED_EN
    is_signed = 1'b1;
    run_op(32'hFFFFFFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "signed_m3x5");
    is_signed = 1'b0;
    run_op(32'hFFFFFFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, "unsigned_m3x5");
`endif

    // random operations against the arithmetic model
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 3) ra = ra & 32'h0000_00FF;
`ifdef MULT_SIGNED_EN
      is_signed = 1'($urandom_range(0, 1));
      run_op(ra, rb, model(ra, rb, is_signed), $sformatf("rand%0d", i));
`else
      run_op(ra, rb, model(ra, rb, 1'b0), $sformatf("rand%0d", i));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
